// File: rtl/complete_arbiter.sv
// Round-robin completion arbiter: picks up to N requesting functional units per cycle
// and stages their completion packets into N registered lanes (lane 0 = highest priority).
// Lane k of ex_comp_out is ex_comp_out[k*PKT_W +: PKT_W], packed MSB..LSB as
// {rob_idx, mispredict, branch_valid, branch_taken, branch_target[31:0]}.
module complete_arbiter #(
  parameter int N            = 2,
  parameter int NUM_FU       = 6,
  parameter int ROB_IDX_BITS = 5
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  stall,
  input  logic [NUM_FU-1:0]                     fu_req,
  input  logic [NUM_FU*ROB_IDX_BITS-1:0]        fu_rob_idx,
  input  logic [NUM_FU-1:0]                     fu_mispredict,
  input  logic [NUM_FU-1:0]                     fu_branch_valid,
  input  logic [NUM_FU-1:0]                     fu_branch_taken,
  input  logic [NUM_FU*32-1:0]                  fu_branch_target,
  output logic [NUM_FU-1:0]                     fu_grant,
  output logic [N-1:0]                          ex_valid_out,
  output logic [N*(ROB_IDX_BITS+35)-1:0]        ex_comp_out
);

  localparam int PKT_W = ROB_IDX_BITS + 35;
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [PKT_W-1:0]     fu_pkt [NUM_FU];
  logic [NUM_FU-1:0]    grant_raw;
  logic [N-1:0]         valid_next;
  logic [N*PKT_W-1:0]   comp_next;
  logic                 grant_ok;
  logic                 any_grant;
  logic                 hit;
  logic [PKT_W-1:0]     pkt;
  int                   scan;
  int                   lane_cnt;
  int                   last_fu;

  // Branch fields are only meaningful when branch_valid is set, so mask them here.
  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      fu_pkt[f] = {fu_rob_idx[f*ROB_IDX_BITS +: ROB_IDX_BITS],
                   fu_mispredict[f],
                   fu_branch_valid[f],
                   fu_branch_taken[f] & fu_branch_valid[f],
                   fu_branch_valid[f] ? fu_branch_target[f*32 +: 32] : 32'h0};
    end
  end

  always_comb begin
    grant_raw  = '0;
    valid_next = '0;
    comp_next  = '0;
    last_fu    = 0;
    lane_cnt   = 0;
    scan       = 0;
    hit        = 1'b0;
    pkt        = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_FU) scan = scan - NUM_FU;
      hit = 1'b0;
      pkt = '0;
      for (int f = 0; f < NUM_FU; f++) begin
        if (f == scan) begin
          hit = fu_req[f];
          pkt = fu_pkt[f];
        end
      end
      if (hit && lane_cnt < N) begin
        for (int f = 0; f < NUM_FU; f++) begin
          if (f == scan) grant_raw[f] = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
          if (k == lane_cnt) begin
            valid_next[k]              = 1'b1;
            comp_next[k*PKT_W +: PKT_W] = pkt;
          end
        end
        last_fu  = scan;
        lane_cnt = lane_cnt + 1;
      end
    end
  end

  // Grants are suppressed whenever the staged lanes cannot be reloaded this cycle.
  always_comb begin
    grant_ok  = !stall && !flush && !reset;
    any_grant = |grant_raw;
    fu_grant  = grant_ok ? grant_raw : '0;
    ptr_next  = (last_fu == NUM_FU - 1) ? '0 : PTR_W'(last_fu + 1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      ex_valid_out <= '0;
      ex_comp_out  <= '0;
    end else if (flush) begin
      ex_valid_out <= '0;
      ex_comp_out  <= '0;
    end else if (!stall) begin
      ex_valid_out <= valid_next;
      ex_comp_out  <= comp_next;
      if (any_grant) rr_ptr <= ptr_next;
    end
  end

endmodule

// File: tb/tb_complete_arbiter.sv
// Randomised + directed bench for complete_arbiter against a queue-based scan-order model.
module tb_complete_arbiter;

  localparam int N      = 2;
  localparam int NUM_FU = 6;
  localparam int RB     = 5;
  localparam int PKT_W  = RB + 35;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   stall;
  logic [NUM_FU-1:0]      fu_req;
  logic [NUM_FU*RB-1:0]   fu_rob_idx;
  logic [NUM_FU-1:0]      fu_mispredict;
  logic [NUM_FU-1:0]      fu_branch_valid;
  logic [NUM_FU-1:0]      fu_branch_taken;
  logic [NUM_FU*32-1:0]   fu_branch_target;
  logic [NUM_FU-1:0]      fu_grant;
  logic [N-1:0]           ex_valid_out;
  logic [N*PKT_W-1:0]     ex_comp_out;

  int checks = 0;
  int errors = 0;

  int                 m_ptr;
  logic [N-1:0]       m_valid;
  logic [N*PKT_W-1:0] m_comp;

  complete_arbiter #(.N(N), .NUM_FU(NUM_FU), .ROB_IDX_BITS(RB)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .stall            (stall),
    .fu_req           (fu_req),
    .fu_rob_idx       (fu_rob_idx),
    .fu_mispredict    (fu_mispredict),
    .fu_branch_valid  (fu_branch_valid),
    .fu_branch_taken  (fu_branch_taken),
    .fu_branch_target (fu_branch_target),
    .fu_grant         (fu_grant),
    .ex_valid_out     (ex_valid_out),
    .ex_comp_out      (ex_comp_out)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PKT_W-1:0] exp_pkt(input int f);
    logic bv;
    bv = fu_branch_valid[f];
    return {fu_rob_idx[f*RB +: RB], fu_mispredict[f], bv, fu_branch_taken[f] & bv,
            bv ? fu_branch_target[f*32 +: 32] : 32'h0};
  endfunction

  // Scan-order list of requesters starting at the pointer; the first N of them win.
  function automatic void model_arb(output logic [NUM_FU-1:0] g, output logic [N-1:0] v,
                                    output logic [N*PKT_W-1:0] c, output int last);
    int order[$];
    g = '0; v = '0; c = '0; last = 0;
    if (reset || flush || stall) return;
    for (int i = 0; i < NUM_FU; i++) begin
      int f = (m_ptr + i) % NUM_FU;
      if (fu_req[f]) order.push_back(f);
    end
    for (int k = 0; k < order.size() && k < N; k++) begin
      g[order[k]]              = 1'b1;
      v[k]                     = 1'b1;
      c[k*PKT_W +: PKT_W]      = exp_pkt(order[k]);
      last                     = order[k];
    end
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_valid = '0; m_comp = '0;
  endfunction

  function automatic void model_step();
    logic [NUM_FU-1:0]  g;
    logic [N-1:0]       v;
    logic [N*PKT_W-1:0] c;
    int                 last;
    if (reset) model_reset();
    else if (flush) begin
      m_valid = '0; m_comp = '0;
    end else if (!stall) begin
      model_arb(g, v, c, last);
      m_valid = v; m_comp = c;
      if (g != 0) m_ptr = (last + 1) % NUM_FU;
    end
  endfunction

  function automatic logic [RB-1:0] lane_rob(input int k);
    return ex_comp_out[k*PKT_W + 35 +: RB];
  endfunction

  always @(negedge clock) begin
    logic [NUM_FU-1:0]  eg;
    logic [N-1:0]       ev;
    logic [N*PKT_W-1:0] ec;
    int                 el;
    model_arb(eg, ev, ec, el);
    checkOutput("grant", fu_grant, eg);
    checkOutput("valid", ex_valid_out, m_valid);
    checkOutput("payload", ex_comp_out, m_comp);
  end

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic set_fu(input int f, input logic [RB-1:0] rob, input logic mis, input logic bv,
                        input logic bt, input logic [31:0] tgt);
    fu_rob_idx[f*RB +: RB]       = rob;
    fu_mispredict[f]             = mis;
    fu_branch_valid[f]           = bv;
    fu_branch_taken[f]           = bt;
    fu_branch_target[f*32 +: 32] = tgt;
  endtask

  task automatic directed_payload();
    for (int f = 0; f < NUM_FU; f++)
      set_fu(f, RB'(f + 10), f[0], 1'b1, f[1], 32'h1000 + f);
  endtask

  task automatic applyStimulus(input logic rs, input logic fl, input logic st, input logic [NUM_FU-1:0] rq);
    reset = rs; flush = fl; stall = st; fu_req = rq;
    if (rs) model_reset();
  endtask

  initial begin
    logic [NUM_FU-1:0] acc;
    model_reset();
    directed_payload();
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    step(); step();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    #1;
    checkOutput("reset_valid", ex_valid_out, 2'b00);
    checkOutput("reset_payload", ex_comp_out, '0);

    // Basic grant from pointer 0.
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b000101);
    #1 checkOutput("basic_grant", fu_grant, 6'b000101);
    step();
    checkOutput("basic_valid", ex_valid_out, 2'b11);
    checkOutput("basic_lane0", lane_rob(0), 5'd10);
    checkOutput("basic_lane1", lane_rob(1), 5'd12);

    // Move the pointer to 5, then exercise wrap-around.
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b010000);
    step();
    checkOutput("single_valid", ex_valid_out, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b100011);
    #1 checkOutput("wrap_grant", fu_grant, 6'b100001);
    step();
    checkOutput("wrap_lane0", lane_rob(0), 5'd15);
    checkOutput("wrap_lane1", lane_rob(1), 5'd10);

    // Stall holds everything.
    applyStimulus(1'b0, 1'b0, 1'b1, 6'b111111);
    #1 checkOutput("stall_grant", fu_grant, 6'b000000);
    step(); step(); step();
    checkOutput("stall_valid", ex_valid_out, 2'b11);
    checkOutput("stall_lane0", lane_rob(0), 5'd15);

    // Flush overrides stall.
    applyStimulus(1'b0, 1'b1, 1'b1, 6'b111111);
    #1 checkOutput("flush_grant", fu_grant, 6'b000000);
    step();
    checkOutput("flush_valid", ex_valid_out, 2'b00);
    checkOutput("flush_payload", ex_comp_out, '0);

    // Pointer must still be 1 after stall/flush.
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b000011);
    #1 checkOutput("ptr_hold_grant", fu_grant, 6'b000011);
    step();
    checkOutput("ptr_hold_lane0", lane_rob(0), 5'd11);
    checkOutput("ptr_hold_lane1", lane_rob(1), 5'd10);

    // Branch field masking.
    set_fu(2, 5'd12, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b000100);
    step();
    checkOutput("mask_valid", ex_valid_out, 2'b01);
    checkOutput("mask_lane0", ex_comp_out[PKT_W-1:0], {5'd12, 1'b1, 1'b0, 1'b0, 32'h0});
    directed_payload();

    // Fairness: all request, every FU served within three cycles.
    acc = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b111111);
    for (int c = 0; c < 3; c++) begin
      #1 acc = acc | fu_grant;
      step();
    end
    checkOutput("fairness", acc, 6'b111111);

    // Asynchronous reset between edges.
    #1 reset = 1'b1;
    #1;
    checkOutput("async_valid", ex_valid_out, 2'b00);
    checkOutput("async_payload", ex_comp_out, '0);
    checkOutput("async_grant", fu_grant, 6'b000000);
    model_reset();
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'b111111);
    #1 checkOutput("post_reset_grant", fu_grant, 6'b000011);
    step();
    checkOutput("post_reset_lane0", lane_rob(0), 5'd10);

    // Randomised traffic checked by the compare process.
    for (int c = 0; c < 600; c++) begin
      for (int f = 0; f < NUM_FU; f++)
        set_fu(f, RB'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom);
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                    $urandom_range(0, 99) < 20, NUM_FU'($urandom));
      step();
    end

    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
